snoop_bus_arbiter: RTL and testbench

//  Round-robin arbiter and broadcast mux for the shared snooping bus between NUM_CORES Processor tiles.

---
 rtl/snoop_bus_pkg.sv | 19 +
 rtl/rr_priority_picker.sv | 29 ++
 rtl/snoop_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_pkg.sv
// Shared snooping-bus types: bus operation encoding, arbiter states and bus width.
// Also used by cache_subsystem_L1.
package snoop_bus_pkg;

    localparam int BUS_W = 32;

    typedef enum logic [1:0] {
        BUS_RD   = 2'b00,
        BUS_UPGR = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_NONE = 2'b11
    } bus_op_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first requester at or after i_ptr,
// wrapping modulo NUM_CORES, plus a valid flag when any request is present.
module rr_priority_picker #(
    parameter int NUM_CORES = 4,
    parameter int PTR_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [PTR_W-1:0]     o_winner,
    output logic                 o_valid
);

    logic [PTR_W-1:0] w_idx;

    // Scan from the farthest candidate back to i_ptr so the closest requester wins.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            w_idx = PTR_W'((int'(i_ptr) + i) % NUM_CORES);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and broadcast mux for the shared snooping bus.
// Optional forced-release hold timeout enabled by defining SNOOP_ARB_TIMEOUT_EN.
module snoop_bus_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int MAX_HOLD  = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          req_core,
    output logic [NUM_CORES-1:0]          grant,
    input  logic [NUM_CORES*BUS_W-1:0]    core_data_in,
    input  logic [NUM_CORES*BUS_W-1:0]    core_addr_in,
    input  logic [NUM_CORES*2-1:0]        core_op_in,
    input  logic [NUM_CORES-1:0]          core_hit_in,
    output logic [BUS_W-1:0]              bus_data_out,
    output logic [BUS_W-1:0]              bus_address_out,
    output logic [1:0]                    bus_operation_out,
    output logic                          bus_hit_out,
    output logic [$clog2(NUM_CORES)-1:0]  bus_owner,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int PTR_W = $clog2(NUM_CORES);

    arb_state_t           r_state;
    arb_state_t           w_stateNxt;
    logic [NUM_CORES-1:0] r_grant;
    logic [NUM_CORES-1:0] w_grantNxt;
    logic [PTR_W-1:0]     r_owner;
    logic [PTR_W-1:0]     w_ownerNxt;
    logic [PTR_W-1:0]     r_rrPtr;
    logic [PTR_W-1:0]     w_rrPtrNxt;
    logic                 r_timeoutErr;
    logic                 w_timeoutNxt;
    logic [PTR_W-1:0]     w_pickWinner;
    logic                 w_pickValid;
    logic [PTR_W-1:0]     w_releasePtr;
    logic [NUM_CORES-1:0] w_ownerOneHot;
    logic                 w_holdExpired;

    rr_priority_picker #(
        .NUM_CORES (NUM_CORES),
        .PTR_W     (PTR_W)
    ) u_picker (
        .i_req    (req_core),
        .i_ptr    (r_rrPtr),
        .o_winner (w_pickWinner),
        .o_valid  (w_pickValid)
    );

    // After a release the pointer moves past the old owner so it gets lowest priority.
    assign w_releasePtr  = (r_owner == PTR_W'(NUM_CORES - 1)) ? '0 : r_owner + 1'b1;
    assign w_ownerOneHot = NUM_CORES'(1) << r_owner;

`ifdef SNOOP_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] r_holdCnt;

    always_ff @(posedge clk) begin
        if (reset || r_state == ARB_IDLE) begin
            r_holdCnt <= '0;
        end else begin
            r_holdCnt <= r_holdCnt + 1'b1;
        end
    end

    assign w_holdExpired = (r_holdCnt == HOLD_W'(MAX_HOLD - 1));
`else
    assign w_holdExpired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_rrPtr      <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_state      <= w_stateNxt;
            r_grant      <= w_grantNxt;
            r_owner      <= w_ownerNxt;
            r_rrPtr      <= w_rrPtrNxt;
            r_timeoutErr <= w_timeoutNxt;
        end
    end

    // No preemption: a granted owner keeps the bus until it drops its request or times out.
    always_comb begin
        w_stateNxt   = r_state;
        w_grantNxt   = r_grant;
        w_ownerNxt   = r_owner;
        w_rrPtrNxt   = r_rrPtr;
        w_timeoutNxt = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pickValid) begin
                    w_stateNxt = ARB_GRANT;
                    w_grantNxt = NUM_CORES'(1) << w_pickWinner;
                    w_ownerNxt = w_pickWinner;
                end
            end
            ARB_GRANT: begin
                if (!req_core[r_owner] || w_holdExpired) begin
                    w_stateNxt   = ARB_IDLE;
                    w_grantNxt   = '0;
                    w_rrPtrNxt   = w_releasePtr;
                    w_timeoutNxt = req_core[r_owner];
                end
            end
            default: begin
                w_stateNxt = ARB_IDLE;
                w_grantNxt = '0;
            end
        endcase
    end

    always_comb begin
        bus_data_out      = '0;
        bus_address_out   = '0;
        bus_operation_out = BUS_NONE;
        bus_hit_out       = 1'b0;
        if (r_state == ARB_GRANT) begin
            bus_data_out      = core_data_in[int'(r_owner)*BUS_W +: BUS_W];
            bus_address_out   = core_addr_in[int'(r_owner)*BUS_W +: BUS_W];
            bus_operation_out = core_op_in[int'(r_owner)*2 +: 2];
            bus_hit_out       = |(core_hit_in & ~w_ownerOneHot);
        end
    end

    assign grant       = r_grant;
    assign bus_owner   = r_owner;
    assign busy        = |r_grant;
    assign timeout_err = r_timeoutErr;

    assert property (@(posedge clk) $onehot0(r_grant));
    assert property (@(posedge clk) (NUM_CORES >= 2 && NUM_CORES <= 8 && MAX_HOLD >= 1));

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level round-robin reference model.
module tb_snoop_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

`ifdef SNOOP_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_core;
    logic [N-1:0]  grant;
    logic [N*32-1:0] core_data_in;
    logic [N*32-1:0] core_addr_in;
    logic [N*2-1:0]  core_op_in;
    logic [N-1:0]  core_hit_in;
    logic [31:0]   bus_data_out;
    logic [31:0]   bus_address_out;
    logic [1:0]    bus_operation_out;
    logic          bus_hit_out;
    logic [1:0]    bus_owner;
    logic          busy;
    logic          timeout_err;

    int nTests = 0;
    int nFail  = 0;

    // Reference model: who owns the bus, where the round-robin search starts, how long held.
    bit mBusy;
    int mOwner;
    int mPtr;
    int mHold;
    bit mTo;

    snoop_bus_arbiter #(
        .NUM_CORES (N),
        .MAX_HOLD  (MH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_core          (req_core),
        .grant             (grant),
        .core_data_in      (core_data_in),
        .core_addr_in      (core_addr_in),
        .core_op_in        (core_op_in),
        .core_hit_in       (core_hit_in),
        .bus_data_out      (bus_data_out),
        .bus_address_out   (bus_address_out),
        .bus_operation_out (bus_operation_out),
        .bus_hit_out       (bus_hit_out),
        .bus_owner         (bus_owner),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic modelEdge();
        mTo = 1'b0;
        if (reset) begin
            mBusy = 1'b0;
            mOwner = 0;
            mPtr = 0;
            mHold = 0;
        end else if (!mBusy) begin
            for (int k = 0; k < N; k++) begin
                if (!mBusy && req_core[(mPtr + k) % N]) begin
                    mBusy = 1'b1;
                    mOwner = (mPtr + k) % N;
                    mHold = 0;
                end
            end
        end else if (!req_core[mOwner]) begin
            mBusy = 1'b0;
            mPtr = (mOwner + 1) % N;
        end else begin
            mHold++;
            if (TIMEOUT_ON && mHold >= MH) begin
                mBusy = 1'b0;
                mPtr = (mOwner + 1) % N;
                mTo = 1'b1;
            end
        end
    endtask

    task automatic step();
        core_data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        core_addr_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        core_op_in   = 8'($urandom());
        core_hit_in  = 4'($urandom());
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        req_core = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [N-1:0] expGrant();
        return mBusy ? 4'(1 << mOwner) : 4'b0000;
    endfunction

    function automatic logic [31:0] expData();
        return mBusy ? core_data_in[32*mOwner +: 32] : 32'h0;
    endfunction

    function automatic logic [31:0] expAddr();
        return mBusy ? core_addr_in[32*mOwner +: 32] : 32'h0;
    endfunction

    function automatic logic [1:0] expOp();
        return mBusy ? core_op_in[2*mOwner +: 2] : 2'b11;
    endfunction

    function automatic logic expHit();
        logic h = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (mBusy && c != mOwner && core_hit_in[c]) h = 1'b1;
        end
        return h;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req_core = '0;
        step();
        nTests++;
        if (bus_owner !== 2'd0) begin
            nFail++;
            $display("[TB] FAIL reset_owner: got %0d expected 0", bus_owner);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            nTests++;
            if (grant !== 4'b0000 || busy !== 1'b0 || bus_operation_out !== 2'b11 ||
                bus_data_out !== 32'h0 || timeout_err !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL reset_idle cycle %0d: grant=%b busy=%b op=%b data=%h to=%b expected 0000/0/11/0/0",
                         i, grant, busy, bus_operation_out, bus_data_out, timeout_err);
            end
        end
    endtask

    task automatic test_single();
        doReset();
        req_core = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            nTests++;
            if (grant !== 4'b0100 || bus_owner !== 2'd2 || busy !== 1'b1) begin
                nFail++;
                $display("[TB] FAIL single_grant cycle %0d: grant=%b owner=%0d busy=%b expected 0100/2/1",
                         i, grant, bus_owner, busy);
            end
            nTests++;
            if (bus_data_out !== core_data_in[95:64] || bus_address_out !== core_addr_in[95:64] ||
                bus_operation_out !== core_op_in[5:4]) begin
                nFail++;
                $display("[TB] FAIL single_mirror: data=%h addr=%h op=%b expected %h/%h/%b",
                         bus_data_out, bus_address_out, bus_operation_out,
                         core_data_in[95:64], core_addr_in[95:64], core_op_in[5:4]);
            end
        end
        req_core = 4'b0000;
        step();
        nTests++;
        if (grant !== 4'b0000 || bus_operation_out !== 2'b11) begin
            nFail++;
            $display("[TB] FAIL single_release: grant=%b op=%b expected 0000/11", grant, bus_operation_out);
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] want;
        doReset();
        req_core = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            want = 4'(1 << order[t]);
            for (int h = 0; h < 3; h++) begin
                step();
                nTests++;
                if (grant !== want) begin
                    nFail++;
                    $display("[TB] FAIL rr_order turn %0d cycle %0d: grant=%b expected %b", t, h, grant, want);
                end
            end
            req_core[order[t]] = 1'b0;
            step();
            nTests++;
            if (grant !== 4'b0000 || bus_operation_out !== 2'b11) begin
                nFail++;
                $display("[TB] FAIL rr_dead_cycle turn %0d: grant=%b op=%b expected 0000/11",
                         t, grant, bus_operation_out);
            end
            req_core = 4'b1111;
        end
        req_core = 4'b0000;
        step();
        step();
    endtask

    task automatic test_hit();
        doReset();
        req_core = 4'b0010;
        step();
        core_hit_in = 4'b1011;
        #1;
        nTests++;
        if (bus_hit_out !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL hit_others: got %b expected 1", bus_hit_out);
        end
        core_hit_in = 4'b0010;
        #1;
        nTests++;
        if (bus_hit_out !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL hit_owner_only: got %b expected 0", bus_hit_out);
        end
        req_core = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        doReset();
        req_core = 4'b0001;
        step();
        req_core = 4'b0000;
        step();
        req_core = 4'b0010;
        step();
        step();
        nTests++;
        if (grant !== 4'b0010) begin
            nFail++;
            $display("[TB] FAIL midreset_pre: grant=%b expected 0010", grant);
        end
        reset = 1'b1;
        step();
        nTests++;
        if (grant !== 4'b0000 || busy !== 1'b0 || bus_operation_out !== 2'b11 || bus_owner !== 2'd0) begin
            nFail++;
            $display("[TB] FAIL midreset_clear: grant=%b busy=%b op=%b owner=%0d expected 0000/0/11/0",
                     grant, busy, bus_operation_out, bus_owner);
        end
        reset = 1'b0;
        req_core = 4'b0011;
        step();
        nTests++;
        if (grant !== 4'b0001) begin
            nFail++;
            $display("[TB] FAIL midreset_ptr: grant=%b expected 0001", grant);
        end
        req_core = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        doReset();
        req_core = 4'b1000;
        step();
        req_core = 4'b1001;
`ifdef SNOOP_ARB_TIMEOUT_EN
        for (int i = 1; i < MH; i++) begin
            step();
            nTests++;
            if (grant !== 4'b1000 || timeout_err !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL timeout_hold cycle %0d: grant=%b to=%b expected 1000/0", i, grant, timeout_err);
            end
        end
        step();
        nTests++;
        if (grant !== 4'b0000 || timeout_err !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL timeout_fire: grant=%b to=%b expected 0000/1", grant, timeout_err);
        end
        step();
        nTests++;
        if (grant !== 4'b0001 || timeout_err !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL timeout_next: grant=%b to=%b expected 0001/0", grant, timeout_err);
        end
`else
        for (int i = 0; i < 80; i++) begin
            step();
            nTests++;
            if (grant !== 4'b1000 || timeout_err !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL no_timeout cycle %0d: grant=%b to=%b expected 1000/0", i, grant, timeout_err);
            end
        end
`endif
        req_core = 4'b0000;
        step();
    endtask

    task automatic test_random();
        doReset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (req_core[c]) begin
                    if ($urandom_range(3) == 0) req_core[c] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    req_core[c] = 1'b1;
                end
            end
            reset = ($urandom_range(99) == 0);
            step();
            nTests++;
            if (grant !== expGrant() || busy !== mBusy || timeout_err !== mTo) begin
                nFail++;
                $display("[TB] FAIL rand_grant cycle %0d: grant=%b busy=%b to=%b expected %b/%b/%b",
                         cyc, grant, busy, timeout_err, expGrant(), mBusy, mTo);
            end
            nTests++;
            if (bus_data_out !== expData() || bus_address_out !== expAddr() ||
                bus_operation_out !== expOp() || bus_hit_out !== expHit()) begin
                nFail++;
                $display("[TB] FAIL rand_bus cycle %0d: data=%h addr=%h op=%b hit=%b expected %h/%h/%b/%b",
                         cyc, bus_data_out, bus_address_out, bus_operation_out, bus_hit_out,
                         expData(), expAddr(), expOp(), expHit());
            end
            if (mBusy) begin
                nTests++;
                if (int'(bus_owner) != mOwner) begin
                    nFail++;
                    $display("[TB] FAIL rand_owner cycle %0d: got %0d expected %0d", cyc, bus_owner, mOwner);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_core = '0;
        core_data_in = '0;
        core_addr_in = '0;
        core_op_in = '0;
        core_hit_in = '0;
        mBusy = 1'b0;
        mOwner = 0;
        mPtr = 0;
        mHold = 0;
        mTo = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_hit();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
